// File: rtl/packet_source_gen_pkg.sv
// packet_source_gen_pkg: shared constants, state encodings and LFSR helpers for the packet source
package packet_source_gen_pkg;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [1:0] S_IDLE = 2'd0, S_ACK_WAIT = 2'd1, S_GAP = 2'd2, S_DONE = 2'd3;
  function automatic int head_bit(input int size);
    return size - 1;
  endfunction
  function automatic int dest_msb(input int size);
    return size - 2;
  endfunction
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
  endfunction
  function automatic logic [31:0] lfsr_seed(input logic [31:0] seed, input logic [31:0] id);
    return (seed ^ id) == 32'd0 ? 32'd1 : seed ^ id;
  endfunction
endpackage

// File: rtl/packet_source_gen_if.sv
// packet_source_gen_if: two-phase req/ack flit channel between a source and a router port
interface packet_source_gen_if #(parameter int SIZE = 8);
  logic req;
  logic ack;
  logic [SIZE-1:0] data;
  modport master (output req, data, input ack);
  modport slave (input req, data, output ack);
endinterface

// File: rtl/packet_source_gen_lfsr32.sv
// packet_source_gen_lfsr32: seeded 32-bit Galois LFSR that steps once per advance pulse
module packet_source_gen_lfsr32
  import packet_source_gen_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd1,
  parameter logic [31:0] ID = 32'd0
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic [31:0] state
);
  always_ff @(posedge clk) begin
    if (reset) state <= lfsr_seed(SEED, ID);
    else if (advance) state <= lfsr_next(state);
  end
endmodule

// File: rtl/packet_source_gen.sv
// packet_source_gen: emits seeded multi-flit packets over a toggle req/ack channel with gap, limit and error flag
module packet_source_gen
  import packet_source_gen_pkg::*;
#(
  parameter int ID = 0,
  parameter int DESTINATION = 0,
  parameter int FLITS = 8,
  parameter int SIZE = 8,
  parameter int DESTINATION_BITS = 4,
  parameter int PACKETS = 0,
  parameter int GAP = 0,
  parameter int SEED = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  packet_source_gen_if.master ch,
  output logic busy,
  output logic done,
  output logic [15:0] packets_sent,
  output logic protocol_err
);
  logic [1:0] state;
  logic ack_old, ack_rx, last, issue;
  logic [7:0] flit_idx;
  logic [15:0] gap_cnt;
  logic [31:0] lfsr;
  logic [SIZE-1:0] flit;

  assign ack_rx = ch.ack ^ ack_old;
  assign last = flit_idx == 8'(FLITS - 1);
  assign issue = (state == S_IDLE && enable && !done) || (state == S_ACK_WAIT && ack_rx && !last);
  assign busy = state == S_ACK_WAIT;
  assign done = state == S_DONE;

  // The head flit is only ever issued from IDLE, so the state alone selects the flit format
  always_comb begin
    flit = SIZE'(lfsr);
    flit[head_bit(SIZE)] = state == S_IDLE;
    if (state == S_IDLE) flit[dest_msb(SIZE) -: DESTINATION_BITS] = DESTINATION_BITS'(DESTINATION);
  end

  packet_source_gen_lfsr32 #(.SEED(32'(SEED)), .ID(32'(ID))) u_lfsr (
    .clk(clk),
    .reset(reset),
    .advance(issue),
    .state(lfsr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ack_old <= 1'b0;
      flit_idx <= 8'd0;
      gap_cnt <= 16'd0;
      ch.req <= 1'b0;
      ch.data <= '0;
      packets_sent <= 16'd0;
      protocol_err <= 1'b0;
    end else begin
      ack_old <= ch.ack;
      if (issue) begin
        ch.data <= flit;
        ch.req <= ~ch.req;
      end
      if (ack_rx && state != S_ACK_WAIT) protocol_err <= 1'b1;
      if (state == S_IDLE && issue) begin
        flit_idx <= 8'd0;
        state <= S_ACK_WAIT;
      end
      if (state == S_ACK_WAIT && ack_rx) begin
        flit_idx <= last ? 8'd0 : flit_idx + 8'd1;
        if (last) begin
          packets_sent <= packets_sent + 16'd1;
          gap_cnt <= 16'(GAP - 1);
          state <= (PACKETS != 0 && 32'(packets_sent) + 32'd1 == 32'(PACKETS)) ? S_DONE :
                   (GAP == 0 ? S_IDLE : S_GAP);
        end
      end
      if (state == S_GAP) begin
        gap_cnt <= gap_cnt - 16'd1;
        if (gap_cnt == 16'd0) state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_packet_source_gen.sv
// tb_packet_source_gen: scoreboard bench for a bounded gapped source (a) and an unbounded back-to-back source (b)
module tb_packet_source_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b1, reset_b = 1'b1, en_a = 1'b1, en_b = 1'b1, flip_a = 1'b0, chk_b = 1'b1;
  logic busy_a, done_a, perr_a, busy_b, done_b, perr_b;
  logic [15:0] sent_a, sent_b;
  int errors = 0, checks = 0, cyc = 0, n_a = 0, n_b = 0;

  typedef struct {logic [7:0] d; int iv;} exp_t;
  exp_t q_a[$], q_b[$];
  // Hand-derived flits for seed 1, destination 5, 4 flits per packet, 8-bit flits
  logic [7:0] exp_d [8] = '{8'hA9, 8'h03, 8'h02, 8'h01, 8'hAB, 8'h02, 8'h01, 8'h03};
  int iv_a [8] = '{0, 2, 2, 2, 6, 2, 2, 2};
  int iv_b [8] = '{0, 2, 2, 2, 3, 2, 2, 2};

  packet_source_gen_if #(.SIZE(8)) if_a ();
  packet_source_gen_if #(.SIZE(8)) if_b ();

  packet_source_gen #(.ID(0), .DESTINATION(5), .FLITS(4), .SIZE(8), .DESTINATION_BITS(4),
                      .PACKETS(2), .GAP(3), .SEED(1)) u_a (
    .clk(clk), .reset(reset_a), .enable(en_a), .ch(if_a), .busy(busy_a), .done(done_a),
    .packets_sent(sent_a), .protocol_err(perr_a));

  packet_source_gen #(.ID(0), .DESTINATION(5), .FLITS(4), .SIZE(8), .DESTINATION_BITS(4),
                      .PACKETS(0), .GAP(0), .SEED(1)) u_b (
    .clk(clk), .reset(reset_b), .enable(en_b), .ch(if_b), .busy(busy_b), .done(done_b),
    .packets_sent(sent_b), .protocol_err(perr_b));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_a();
    for (int i = 0; i < 8; i++) q_a.push_back(exp_t'{d: exp_d[i], iv: iv_a[i]});
  endtask

  // Downstream models: ack follows req two cycles later
  initial begin
    logic [1:0] h;
    h = 2'b00;
    if_a.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_a) begin
        h = 2'b00;
        if_a.ack = 1'b0;
      end else begin
        h = {h[0], if_a.req};
        if_a.ack = h[1] ^ flip_a;
      end
    end
  end

  initial begin
    logic [1:0] h;
    h = 2'b00;
    if_b.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_b) begin
        h = 2'b00;
        if_b.ack = 1'b0;
      end else begin
        h = {h[0], if_b.req};
        if_b.ack = h[1];
      end
    end
  end

  initial begin
    logic prev;
    int last;
    exp_t e;
    prev = 1'b0;
    last = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_a) begin
        prev = 1'b0;
        n_a = 0;
      end else if (if_a.req !== prev) begin
        prev = if_a.req;
        n_a++;
        check("a_flit_expected", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          check("a_data", 32'(if_a.data), 32'(e.d));
          check("a_busy", 32'(busy_a), 32'd1);
          if (e.iv != 0) check("a_req_interval", 32'(cyc - last), 32'(e.iv));
        end
        last = cyc;
      end
    end
  end

  initial begin
    logic prev;
    int last;
    logic head;
    exp_t e;
    prev = 1'b0;
    last = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset_b) begin
        prev = 1'b0;
        n_b = 0;
      end else if (if_b.req !== prev) begin
        prev = if_b.req;
        n_b++;
        head = ((n_b - 1) % 4) == 0;
        check("b_busy", 32'(busy_b), 32'd1);
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          check("b_data", 32'(if_b.data), 32'(e.d));
          if (e.iv != 0) check("b_req_interval", 32'(cyc - last), 32'(e.iv));
        end else begin
          check("b_head_bit", 32'(if_b.data[7]), 32'(head));
          if (head) check("b_dest", 32'(if_b.data[6:3]), 32'd5);
          if (chk_b) check("b_req_interval", 32'(cyc - last), head ? 32'd3 : 32'd2);
        end
        last = cyc;
      end
    end
  end

  initial begin
    int t, m;
    load_a();
    for (int i = 0; i < 8; i++) q_b.push_back(exp_t'{d: exp_d[i], iv: iv_b[i]});
    tick();
    tick();
    check("a_reset_req", 32'(if_a.req), 32'd0);
    check("a_reset_data", 32'(if_a.data), 32'd0);
    check("a_reset_busy", 32'(busy_a), 32'd0);
    check("a_reset_done", 32'(done_a), 32'd0);
    check("a_reset_sent", 32'(sent_a), 32'd0);
    check("a_reset_perr", 32'(perr_a), 32'd0);
    check("b_reset_req", 32'(if_b.req), 32'd0);
    @(negedge clk);
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick();
    check("a_first_edge_req", 32'(if_a.req), 32'd1);
    check("a_first_edge_busy", 32'(busy_a), 32'd1);
    t = 0;
    while (!done_a && t < 200) begin tick(); t++; end
    check("a_done", 32'(done_a), 32'd1);
    check("a_sent_at_done", 32'(sent_a), 32'd2);
    check("a_perr_clean", 32'(perr_a), 32'd0);
    check("a_all_flits_seen", 32'(q_a.size()), 32'd0);
    repeat (100) tick();
    check("a_quiet_after_done", 32'(n_a), 32'd8);
    check("a_done_sticky", 32'(done_a), 32'd1);

    @(negedge clk);
    reset_a = 1'b1;
    load_a();
    tick();
    tick();
    @(negedge clk);
    reset_a = 1'b0;
    t = 0;
    while (!(sent_a == 16'd1 && !busy_a) && t < 100) begin tick(); t++; end
    check("a_reach_gap", 32'(sent_a == 16'd1 && !busy_a && !done_a), 32'd1);
    @(negedge clk);
    flip_a = ~flip_a;
    repeat (3) tick();
    check("a_perr_in_gap", 32'(perr_a), 32'd1);
    t = 0;
    while (!done_a && t < 200) begin tick(); t++; end
    check("a_done_after_perr", 32'(done_a), 32'd1);
    check("a_perr_sticky", 32'(perr_a), 32'd1);
    check("a_flits_after_perr", 32'(q_a.size()), 32'd0);

    @(negedge clk);
    reset_a = 1'b1;
    flip_a = 1'b0;
    load_a();
    tick();
    tick();
    @(negedge clk);
    reset_a = 1'b0;
    t = 0;
    while (n_a != 3 && t < 50) begin tick(); t++; end
    check("a_reach_flit2", 32'(n_a), 32'd3);
    @(negedge clk);
    reset_a = 1'b1;
    tick();
    check("a_midreset_req", 32'(if_a.req), 32'd0);
    check("a_midreset_data", 32'(if_a.data), 32'd0);
    check("a_midreset_sent", 32'(sent_a), 32'd0);
    check("a_midreset_perr", 32'(perr_a), 32'd0);
    check("a_midreset_busy", 32'(busy_a), 32'd0);
    q_a.delete();
    load_a();
    @(negedge clk);
    reset_a = 1'b0;
    t = 0;
    while (!done_a && t < 200) begin tick(); t++; end
    check("a_replay_done", 32'(done_a), 32'd1);
    check("a_replay_sent", 32'(sent_a), 32'd2);
    check("a_replay_flits", 32'(q_a.size()), 32'd0);

    t = 0;
    while (sent_b <= 16'd1000 && t < 20000) begin tick(); t++; end
    check("b_past_1000", 32'(sent_b > 16'd1000), 32'd1);
    check("b_never_done", 32'(done_b), 32'd0);
    check("b_perr_clean", 32'(perr_b), 32'd0);
    t = 0;
    while ((n_b % 4) != 3 && t < 50) begin tick(); t++; end
    check("b_reach_flit2", 32'(n_b % 4), 32'd3);
    @(negedge clk);
    en_b = 1'b0;
    chk_b = 1'b0;
    t = 0;
    while (busy_b && t < 50) begin tick(); t++; end
    m = n_b;
    check("b_packet_completes", 32'(m % 4), 32'd0);
    repeat (20) tick();
    check("b_hold_while_disabled", 32'(n_b), 32'(m));
    check("b_idle_while_disabled", 32'(busy_b), 32'd0);
    @(negedge clk);
    en_b = 1'b1;
    tick();
    check("b_resume_next_edge", 32'(n_b), 32'(m + 1));
    check("b_resume_busy", 32'(busy_b), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
